// File: rtl/mode_counter_pkg.sv
// mode_counter_pkg: mode encodings and code-conversion helpers shared by the
// multi-mode sequence counter. Helpers work on a fixed MAXW+1 bit container
// so they can serve any counter width up to MAXW; callers size-cast results.
package mode_counter_pkg;

    localparam int MAXW = 16;

    typedef logic [MAXW:0] wide_t;

    typedef enum logic [1:0] {
        BIN_UP  = 2'd0,
        BIN_DN  = 2'd1,
        GRAY    = 2'd2,
        JOHNSON = 2'd3
    } mode_e;

    function automatic wide_t bin2gray(input wide_t b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all gray bits at or above it.
    function automatic wide_t gray2bin(input wide_t g);
        wide_t b;
        b = g;
        for (int i = 1; i <= MAXW; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    // Legal Johnson codes are k ones packed at the bottom (0..01..1) or the
    // complement within the width (1..10..0), for k = 0..width.
    function automatic logic johnson_valid(input wide_t code, input int width);
        wide_t mask;
        wide_t ones;
        logic  ok;
        mask = wide_t'((1 << width) - 1);
        ok   = 1'b0;
        for (int k = 0; k <= MAXW; k++) begin
            if (k <= width) begin
                ones = wide_t'((1 << k) - 1);
                if (code == ones || code == (mask & ~ones)) ok = 1'b1;
            end
        end
        return ok;
    endfunction

    function automatic wide_t start_val(input logic [1:0] m, input int mod);
        return (m == BIN_DN) ? wide_t'(mod - 1) : '0;
    endfunction

    // Terminal value expressed in the output encoding of the mode.
    function automatic wide_t terminal_val(input logic [1:0] m, input int mod,
                                           input int width);
        wide_t t;
        case (m)
            BIN_UP:  t = wide_t'(mod - 1);
            BIN_DN:  t = '0;
            GRAY:    t = bin2gray(wide_t'((1 << width) - 1));
            default: t = wide_t'(1) << (width - 1);
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mode_counter_dff.sv
// dff_bank: W-bit register with synchronous active-high reset to a
// run-time reset value.
//   clk     clock
//   reset   synchronous reset, active high
//   rst_val value loaded while reset is high
//   d       next value
//   q       registered value
module dff_bank #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] rst_val,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) q <= rst_val;
        else       q <= d;
    end

endmodule

// File: rtl/mode_counter.sv
// mode_counter: WIDTH-bit sequencer stepping through modulo-MOD binary up,
// modulo-MOD binary down, Gray or Johnson sequences, with enable, validated
// synchronous load, terminal-count flag and restart on mode change.
//   clk       clock
//   reset     synchronous reset, active high
//   en        count enable
//   load      synchronous load strobe
//   load_val  load value, in the output encoding of the current mode
//   mode      0 BIN_UP, 1 BIN_DN, 2 GRAY, 3 JOHNSON
//   out       registered count in the current mode's encoding
//   tc        terminal count (combinational), high in the wrapping cycle
//   load_err  one-cycle pulse after a rejected load
module mode_counter
    import mode_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             load_err
);

    // Binary-mode bounds carried one bit wider so MOD = 2**WIDTH is exact.
    localparam logic [WIDTH:0] MOD_W = (WIDTH + 1)'(MOD);
    localparam logic [WIDTH:0] MAX_W = (WIDTH + 1)'(MOD - 1);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] s_nxt;
    logic [WIDTH-1:0] s_step;
    logic [WIDTH-1:0] s_load;
    logic [WIDTH-1:0] out_nxt;
    logic [WIDTH-1:0] rst_s;
    logic [WIDTH-1:0] term;
    logic [WIDTH:0]   s_ext;
    logic [1:0]       mode_q;
    logic             mode_chg;
    logic             load_ok;
    logic             err_nxt;

    assign mode_chg = (mode != mode_q);
    assign s_ext    = {1'b0, s};
    // All start values encode to themselves (gray(0) = 0), so the same
    // reset value serves both the index and the output register.
    assign rst_s    = WIDTH'(start_val(mode, MOD));
    assign term     = WIDTH'(terminal_val(mode_q, MOD, WIDTH));

    always_comb begin
        s_step = s;
        case (mode_q)
            BIN_UP:  s_step = (s_ext == MAX_W) ? '0 : WIDTH'(s_ext + 1'b1);
            BIN_DN:  s_step = (s == '0) ? WIDTH'(MAX_W) : WIDTH'(s_ext - 1'b1);
            GRAY:    s_step = WIDTH'(s_ext + 1'b1);
            default: s_step = {s[WIDTH-2:0], ~s[WIDTH-1]};
        endcase
    end

    always_comb begin
        load_ok = 1'b1;
        s_load  = load_val;
        case (mode_q)
            BIN_UP, BIN_DN: load_ok = ({1'b0, load_val} < MOD_W);
            GRAY:           s_load  = WIDTH'(gray2bin(wide_t'(load_val)));
            default:        load_ok = johnson_valid(wide_t'(load_val), WIDTH);
        endcase
    end

    // Priority: mode change > load > step > hold. A rejected load freezes
    // the counter for that edge even when en is high.
    always_comb begin
        s_nxt   = s;
        err_nxt = 1'b0;
        if (mode_chg) begin
            s_nxt = rst_s;
        end else if (load) begin
            if (load_ok) s_nxt   = s_load;
            else         err_nxt = 1'b1;
        end else if (en) begin
            s_nxt = s_step;
        end
    end

    // Output is re-encoded from the next index so it stays purely registered.
    assign out_nxt = (mode == GRAY) ? WIDTH'(bin2gray(wide_t'(s_nxt))) : s_nxt;

    assign tc = en & ~reset & ~load & ~mode_chg & (out == term);

    dff_bank #(.W(WIDTH)) u_s (
        .clk     (clk),
        .reset   (reset),
        .rst_val (rst_s),
        .d       (s_nxt),
        .q       (s)
    );

    dff_bank #(.W(WIDTH)) u_out (
        .clk     (clk),
        .reset   (reset),
        .rst_val (rst_s),
        .d       (out_nxt),
        .q       (out)
    );

    always_ff @(posedge clk) begin
        mode_q <= mode;
        if (reset) load_err <= 1'b0;
        else       load_err <= err_nxt;
    end

endmodule

// File: tb/tb_mode_counter.sv
// Table-driven bench for mode_counter. A WIDTH=4/MOD=10 instance carries most
// vectors; a WIDTH=3 instance (same stimulus) checks the 3-bit Gray sequence.
module tb_mode_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic [1:0] mode;
    logic [3:0] out;
    logic       tc;
    logic       load_err;
    logic [2:0] out3;
    logic       tc3;
    logic       load_err3;

    always #5 clk = ~clk;

    mode_counter #(.WIDTH(4), .MOD(10)) dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
        .mode(mode), .out(out), .tc(tc), .load_err(load_err)
    );

    mode_counter #(.WIDTH(3)) dut3 (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val[2:0]),
        .mode(mode), .out(out3), .tc(tc3), .load_err(load_err3)
    );

    typedef struct {
        bit       rst;
        bit [1:0] md;
        bit       e;
        bit       ld;
        bit [3:0] lv;
        bit       c3;   // check the 3-bit instance instead of the 4-bit one
        bit [3:0] eo;
        bit       etc;
        bit       eerr;
    } vec_t;

    typedef struct {
        int       idx;
        bit       c3;
        bit [3:0] eo;
        bit       eerr;
    } exp_t;

    vec_t vq[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input bit rst, input bit [1:0] md, input bit e, input bit ld,
                       input bit [3:0] lv, input bit c3, input bit [3:0] eo,
                       input bit etc, input bit eerr);
        vec_t v;
        v.rst = rst; v.md = md; v.e = e; v.ld = ld; v.lv = lv;
        v.c3 = c3; v.eo = eo; v.etc = etc; v.eerr = eerr;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [3:0] act,
                       input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        exp_t x;
        @(negedge clk);
        reset = v.rst; mode = v.md; en = v.e; load = v.ld; load_val = v.lv;
        #1;
        if (v.c3) chk("tc3", idx, {3'b0, tc3}, {3'b0, v.etc});
        else      chk("tc",  idx, {3'b0, tc},  {3'b0, v.etc});
        x.idx = idx; x.c3 = v.c3; x.eo = v.eo; x.eerr = v.eerr;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        if (x.c3) begin
            chk("out3", x.idx, {1'b0, out3}, x.eo);
            chk("err3", x.idx, {3'b0, load_err3}, {3'b0, x.eerr});
        end else begin
            chk("out", x.idx, out, x.eo);
            chk("err", x.idx, {3'b0, load_err}, {3'b0, x.eerr});
        end
    endtask

    initial begin
        bit [3:0] jtab[8];
        bit [3:0] gtab[8];
        jtab = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
        gtab = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4};

        reset = 1'b1; mode = 2'd0; en = 1'b0; load = 1'b0; load_val = '0;

        // BIN_UP, MOD=10: 0..9, 0; tc only at 9
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 11; i++) add(0, 0, 1, 0, 0, 0, 4'((i + 1) % 10), i == 9, 0);
        // BIN_DN: reset to 9, down to 0, wrap to 9; tc at 0
        add(1, 1, 1, 0, 0, 0, 9, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 1, 1, 0, 0, 0, 4'((18 - i) % 10), i == 9, 0);
        // JOHNSON, WIDTH=4; tc at 1000
        add(1, 3, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) add(0, 3, 1, 0, 0, 0, jtab[(i + 1) % 8], i == 7, 0);
        // GRAY, WIDTH=3 instance; tc at 4
        add(1, 2, 1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) add(0, 2, 1, 0, 0, 1, gtab[(i + 1) % 8], i == 7, 0);

        // Loads in BIN_UP: 12 and 10 rejected (out frozen despite en), 9 accepted
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 0, 0, 0, 2, 0, 0);
        add(0, 0, 1, 0, 0, 0, 3, 0, 0);
        add(0, 0, 1, 1, 12, 0, 3, 0, 1);
        add(0, 0, 1, 1, 10, 0, 3, 0, 1);
        add(0, 0, 0, 0, 0, 0, 3, 0, 0);
        add(0, 0, 0, 1, 9, 0, 9, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1, 0);
        // JOHNSON loads: 0101 rejected, 0111 accepted then steps to 1111
        add(0, 3, 1, 0, 0, 0, 0, 0, 0);
        add(0, 3, 1, 0, 0, 0, 1, 0, 0);
        add(0, 3, 1, 0, 0, 0, 3, 0, 0);
        add(0, 3, 1, 1, 4'b0101, 0, 3, 0, 1);
        add(0, 3, 0, 1, 4'b0111, 0, 7, 0, 0);
        add(0, 3, 1, 0, 0, 0, 4'hF, 0, 0);
        // GRAY load on 4-bit: gray 0110 (=4) then step to gray(5)=0111
        add(0, 2, 0, 0, 0, 0, 0, 0, 0);
        add(0, 2, 0, 1, 4'b0110, 0, 6, 0, 0);
        add(0, 2, 1, 0, 0, 0, 7, 0, 0);
        // Mode toggling: held at start values, tc suppressed even at out=9
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 9, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 9, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);

        // Mode change beats load; reset mid-count discards load; en=0 holds
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) add(0, 0, 1, 0, 0, 0, 4'(i), 0, 0);
        add(0, 1, 1, 1, 3, 0, 9, 0, 0);
        add(0, 1, 1, 0, 0, 0, 8, 0, 0);
        add(0, 1, 1, 0, 0, 0, 7, 0, 0);
        add(1, 1, 1, 1, 2, 0, 9, 0, 0);
        add(0, 1, 0, 0, 0, 0, 9, 0, 0);
        add(0, 1, 0, 0, 0, 0, 9, 0, 0);

        for (int i = 0; i < vq.size(); i++) apply(i, vq[i]);

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mode_counter.md
# mode_counter

Parametrised multi-mode sequence counter: a WIDTH-bit register bank stepped once per enabled clock through one of four run-time-selectable sequences (modulo-MOD binary up, modulo-MOD binary down, Gray, Johnson). It adds enable, synchronous load with code validation, terminal-count flagging and restart on mode change. It replaces the fixed-sequence DFF counters as the general sequencer for timing and state-stepping logic.

## Interface
- WIDTH, 4, counter width in bits; legal range 2..16.
- MOD, 2**WIDTH, modulus for the binary modes; legal range 2..2**WIDTH. Ignored by the Gray and Johnson modes.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load, in the output encoding of the current mode.
- mode  in  2  0 = BIN_UP, 1 = BIN_DN, 2 = GRAY, 3 = JOHNSON.
- out  out  WIDTH  registered count, in the encoding of the current mode.
- tc  out  1  terminal count, combinational.
- load_err  out  1  registered one-cycle pulse; a load was rejected.

## Operation
- Internal state:
  - s[WIDTH-1:0]: binary index. For JOHNSON it holds the raw Johnson code.
  - mode_q: registered copy of mode.
- out is registered together with s: out <= enc(next_s). out is never decoded combinationally.
- Start value per mode: BIN_UP 0, BIN_DN MOD-1, GRAY 0, JOHNSON 0.
- Step per mode:
  - BIN_UP: s+1; MOD-1 wraps to 0.
  - BIN_DN: s-1; 0 wraps to MOD-1.
  - GRAY: s+1 mod 2**WIDTH; out = s ^ (s>>1).
  - JOHNSON: s <= {s[WIDTH-2:0], ~s[WIDTH-1]}, giving 2*WIDTH states.
- Priority per edge, highest first: reset > mode change > load > en step > hold.
  - reset: mode_q <= mode; s and out <= start value of mode; load_err <= 0.
  - mode change (mode != mode_q): mode_q <= mode; s <= start value of the new mode. Applies regardless of en. A load in the same cycle is dropped with no error.
  - load with a valid load_val: s <= load_val, converted gray-to-binary in GRAY mode. load_err <= 0.
  - load with an invalid load_val: s unchanged and no step is taken, even with en = 1. load_err <= 1.
    - Binary modes: invalid when load_val >= MOD.
    - JOHNSON: invalid when load_val is not one of the 2*WIDTH legal codes, i.e. not of the form 0..01..1 or 1..10..0.
    - GRAY: every value is valid.
  - en = 1: one step.
  - en = 0: hold.
- Terminal values:
  - BIN_UP: out = MOD-1.
  - BIN_DN: out = 0.
  - GRAY: out = gray(2**WIDTH - 1).
  - JOHNSON: out = 1 followed by WIDTH-1 zeros.
- tc = en & ~reset & ~load & (mode == mode_q) & (out == terminal). It is high exactly in the cycle whose edge wraps the counter.
- Arithmetic is done at WIDTH+1 bits internally, so MOD = 2**WIDTH wraps without overflow aliasing.

## Timing
- Latency: one edge from en, load or mode to a change on out. load_err is valid the cycle after the load.
- Reset value of out: start value of mode sampled at reset (0, or MOD-1 in BIN_DN). tc = 0 and load_err = 0 during reset.
- Reset asserted mid-count: out returns to the start value on the next edge, and any pending load is discarded.
- Continuous en in BIN_UP: out cycles with period MOD. tc has duty 1/MOD.
- Mode toggling every cycle: out is held at successive start values and tc never asserts.

## Structure
- Package mode_counter_pkg holds:
  - mode encoding constants BIN_UP, BIN_DN, GRAY, JOHNSON;
  - functions bin2gray, gray2bin, johnson_valid, start_val(mode, MOD), terminal_val(mode, MOD, WIDTH).
- Sub-module dff_bank: WIDTH-parametrised register with synchronous active-high reset and a reset-value input. Instantiated for s and for out. Next-state logic lives in mode_counter.

## Test plan
- WIDTH=4, MOD=10, BIN_UP, en held high from reset -> out 0..9, 0. tc high only while out = 9.
- BIN_DN, MOD=10 -> reset out = 9; sequence 9..0, 9. tc high at 0.
- GRAY, WIDTH=3 -> out 0, 1, 3, 2, 6, 7, 5, 4, 0. tc high at 4.
- JOHNSON, WIDTH=4 -> out 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000. tc high at 1000.
- Loads:
  - BIN_UP, load 12 with MOD=10 -> load_err pulse, out unchanged.
  - JOHNSON, load 0101 -> load_err pulse, out unchanged.
  - Load 0111 in JOHNSON -> accepted, next step gives 1111.
- BIN_UP at out = 5: switch mode to BIN_DN with load = 1 -> out = 9 next edge, no load_err. Then reset mid-count -> out = 9; then en = 0 -> out held.
